// File: rtl/rv_clint_pkg.sv
// rv_clint_pkg: shared constants and types for the core-local interruptor.
//   - CLINT window offsets for msip, mtimecmp and mtime
//   - mtimecmp reset value
//   - clint_region_e: decoded target region of a register access
package rv_clint_pkg;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } clint_region_e;

endpackage

// File: rtl/rv_clint_hart.sv
// rv_clint_hart: per-hart CLINT state.
//   clk, rst  : clock, synchronous active-high reset
//   we        : accepted write strobe (already qualified by acceptance)
//   msip_sel  : access targets this hart's msip word
//   cmp_sel   : access targets this hart's mtimecmp
//   cmp_hi    : 1 = mtimecmp upper word, 0 = lower word
//   wdata     : write data
//   mtime     : current mtime
//   msip      : software interrupt pending bit
//   mtip      : registered (mtime >= mtimecmp)
//   rdata     : read slice, zero unless this hart is selected
module rv_clint_hart
  import rv_clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        msip_sel,
  input  logic        cmp_sel,
  input  logic        cmp_hi,
  input  logic [31:0] wdata,
  input  logic [63:0] mtime,
  output logic        msip,
  output logic        mtip,
  output logic [31:0] rdata
);

  logic [63:0] mtimecmp;

  always_ff @(posedge clk) begin
    if (rst) begin
      msip     <= 1'b0;
      mtimecmp <= MTIMECMP_RESET;
      mtip     <= 1'b0;
    end else begin
      if (we && msip_sel) msip <= wdata[0];
      if (we && cmp_sel) begin
        if (cmp_hi) mtimecmp[63:32] <= wdata;
        else        mtimecmp[31:0]  <= wdata;
      end
      mtip <= (mtime >= mtimecmp);
    end
  end

  always_comb begin
    rdata = '0;
    if (msip_sel)     rdata = {31'b0, msip};
    else if (cmp_sel) rdata = cmp_hi ? mtimecmp[63:32] : mtimecmp[31:0];
  end

endmodule

// File: rtl/rv_clint.sv
// rv_clint: core-local interruptor (mtime, per-hart mtimecmp and msip).
//   CLK, RST : clock, synchronous active-high reset
//   w_req    : register access request (single cycle)
//   w_we     : 1 = write, 0 = read
//   w_addr   : byte offset in the CLINT window, bits [1:0] ignored
//   w_wdata  : write data
//   r_ack    : completion pulse, one cycle after an accepted request
//   r_rdata  : read data while r_ack=1, otherwise 0
//   w_mtime  : current mtime
//   w_mtip   : per-hart timer interrupt pending
//   w_msip   : per-hart software interrupt pending
module rv_clint
  import rv_clint_pkg::*;
#(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               w_req,
  input  logic               w_we,
  input  logic [15:0]        w_addr,
  input  logic [31:0]        w_wdata,
  output logic               r_ack,
  output logic [31:0]        r_rdata,
  output logic [63:0]        w_mtime,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [63:0]   mtime;
  logic          accept;
  logic          wr_en;
  logic [11:0]   msip_idx;
  logic [10:0]   cmp_idx;
  clint_region_e region;
  logic [31:0]   rd_value;
  logic [31:0]   hart_rdata [N_HARTS];
  logic          wr_mtime_lo;
  logic          wr_mtime_hi;
  logic          addr_unused;

  assign addr_unused = ^w_addr[1:0];

  // A request arriving while the previous ack is out is ignored.
  assign accept   = w_req && !r_ack;
  assign wr_en    = accept && w_we;
  assign msip_idx = w_addr[13:2];
  assign cmp_idx  = w_addr[13:3];
  assign tick     = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    region = REG_NONE;
    if (w_addr[15:14] == CLINT_MSIP_BASE[15:14] && msip_idx < 12'(N_HARTS))
      region = REG_MSIP;
    else if (w_addr[15:14] == CLINT_MTIMECMP_BASE[15:14] && cmp_idx < 11'(N_HARTS))
      region = REG_MTIMECMP;
    else if (w_addr[15:3] == CLINT_MTIME_LO[15:3])
      region = REG_MTIME;
  end

  assign wr_mtime_lo = wr_en && region == REG_MTIME && w_addr[2] == CLINT_MTIME_LO[2];
  assign wr_mtime_hi = wr_en && region == REG_MTIME && w_addr[2] == CLINT_MTIME_HI[2];

  // An mtime write overrides the tick increment; the prescaler keeps running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      mtime <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (wr_mtime_lo)      mtime[31:0]  <= w_wdata;
      else if (wr_mtime_hi) mtime[63:32] <= w_wdata;
      else if (tick)        mtime        <= mtime + 64'd1;
    end
  end

  for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
    rv_clint_hart u_hart (
      .clk      (CLK),
      .rst      (RST),
      .we       (wr_en),
      .msip_sel (region == REG_MSIP && msip_idx == 12'(h)),
      .cmp_sel  (region == REG_MTIMECMP && cmp_idx == 11'(h)),
      .cmp_hi   (w_addr[2]),
      .wdata    (w_wdata),
      .mtime    (mtime),
      .msip     (w_msip[h]),
      .mtip     (w_mtip[h]),
      .rdata    (hart_rdata[h])
    );
  end

  // Hart slices are zero unless selected, so they can simply be ORed.
  always_comb begin
    rd_value = '0;
    if (region == REG_MTIME) begin
      rd_value = w_addr[2] ? mtime[63:32] : mtime[31:0];
    end else begin
      for (int unsigned i = 0; i < N_HARTS; i++) rd_value = rd_value | hart_rdata[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= accept;
      r_rdata <= (accept && !w_we) ? rd_value : '0;
    end
  end

  assign w_mtime = mtime;

endmodule
